bf16_addsub_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one `pplbf16addsub` pipelined BF16 add/sub unit among `NREQ` requesters, such as SIMT lanes or a vector-op issue slot. It accepts at most one operation per cycle, registers the operands into the unit, and tracks each operation's requester ID in a tag pipeline aligned to the unit's fixed latency. It returns each result to the requester that issued it, in a registered response stage. The add/sub unit cannot stall, so requesters must always accept responses.

---
 rtl/bf16_addsub_arb.sv | 118 +++++++++++
 tb/tb_bf16_addsub_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_addsub_arb.sv
// Round-robin front end for one shared, non-stalling pipelined BF16 add/sub unit.
// Requester IDs ride a tag pipe matched to the unit latency so results return to their issuer.
module bf16_addsub_arb #(
    parameter int NREQ = 4,
    parameter int LAT  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*16-1:0]      req_a,
    input  logic [NREQ*16-1:0]      req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic [15:0]             fu_a,
    output logic [15:0]             fu_b,
    output logic                    fu_sub,
    output logic                    fu_valid,
    input  logic [15:0]             fu_result,
    input  logic                    fu_valid_out,
    output logic [NREQ-1:0]         resp_valid,
    output logic [15:0]             resp_data,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    idle,
    output logic                    err_orphan
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] gid;
    logic           gvld;
    logic           grant_en;
    logic [IDW-1:0] iss_id_p0;
    logic [LAT-1:0] tag_vld_p;
    logic [IDW-1:0] tag_id_p [LAT];
    logic           tail_vld;
    logic [IDW-1:0] tail_id;
    logic           capture;

    // Search starts at ptr and wraps, so the last winner has lowest priority next time.
    always_comb begin
        idx  = '0;
        gid  = '0;
        gvld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!gvld && req_valid[idx]) begin
                gvld = 1'b1;
                gid  = idx;
            end
        end
    end

    assign grant_en  = gvld && issue_en && rst_n;
    assign req_ready = grant_en ? (NREQ'(1) << gid) : '0;
    assign ptr_nxt   = (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);

    // Stage p0: issue register feeding the unit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            fu_valid  <= 1'b0;
            fu_a      <= '0;
            fu_b      <= '0;
            fu_sub    <= 1'b0;
            iss_id_p0 <= '0;
        end else begin
            fu_valid <= grant_en;
            if (grant_en) begin
                ptr       <= ptr_nxt;
                fu_a      <= req_a[int'(gid)*16 +: 16];
                fu_b      <= req_b[int'(gid)*16 +: 16];
                fu_sub    <= req_sub[gid];
                iss_id_p0 <= gid;
            end
        end
    end

    // Stages p1..pLAT: tag pipe, tail aligned with fu_valid_out
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[0] <= fu_valid;
            for (int k = 1; k < LAT; k++) tag_vld_p[k] <= tag_vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id_p[0] <= iss_id_p0;
        for (int k = 1; k < LAT; k++) tag_id_p[k] <= tag_id_p[k-1];
    end

    assign tail_vld = tag_vld_p[LAT-1];
    assign tail_id  = tag_id_p[LAT-1];
    assign capture  = fu_valid_out && tail_vld;

    // Response stage: one-hot strobe to the issuing requester
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
            err_orphan <= 1'b0;
        end else begin
            resp_valid <= capture ? (NREQ'(1) << tail_id) : '0;
            if (capture) begin
                resp_data <= fu_result;
                resp_id   <= tail_id;
            end
            if (fu_valid_out && !tail_vld) err_orphan <= 1'b1;
        end
    end

    assign idle = !fu_valid && !(|tag_vld_p) && !(|resp_valid);
endmodule

// File: tb/tb_bf16_addsub_arb.sv
// Bench for bf16_addsub_arb: a behavioural add/sub unit, round-robin grant model and response scoreboard.
module tb_bf16_addsub_arb;
    localparam int NREQ = 4;
    localparam int LAT  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_en = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a = '0;
    logic [NREQ*16-1:0] req_b = '0;
    logic [NREQ-1:0]   req_sub = '0;
    logic [15:0]       fu_a, fu_b;
    logic              fu_sub, fu_valid;
    logic [15:0]       fu_result;
    logic              fu_valid_out;
    logic [NREQ-1:0]   resp_valid;
    logic [15:0]       resp_data;
    logic [1:0]        resp_id;
    logic              idle, err_orphan;
    logic              inject = 1'b0;

    bf16_addsub_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .fu_a(fu_a), .fu_b(fu_b), .fu_sub(fu_sub), .fu_valid(fu_valid),
        .fu_result(fu_result), .fu_valid_out(fu_valid_out),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
        .idle(idle), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // Exact BF16 <-> real conversion; operands are small integers so every sum is exact.
    function automatic real bf2r(input logic [15:0] x);
        real v;
        int  e;
        if (x[14:0] == 15'd0) return 0.0;
        v = 1.0 + real'(x[6:0]) / 128.0;
        e = int'(x[14:7]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return x[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2bf(input real v);
        logic       s;
        real        a;
        int         e;
        logic [6:0] m;
        if (v == 0.0) return 16'h0000;
        s = (v < 0.0);
        a = s ? -v : v;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m = 7'($rtoi((a - 1.0) * 128.0));
        return {s, 8'(e), m};
    endfunction

    function automatic logic [15:0] bf_op(input logic [15:0] a, input logic [15:0] b, input logic sub);
        return r2bf(sub ? bf2r(a) - bf2r(b) : bf2r(a) + bf2r(b));
    endfunction

    function automatic logic [15:0] rnd_bf();
        return r2bf(real'(int'($urandom_range(0, 16)) - 8));
    endfunction

    // Stand-in for the shared pipelined unit: fixed LAT, no stall, shares rst_n.
    logic        pv [LAT];
    logic [15:0] pr [LAT];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= fu_valid;
            pr[0] <= bf_op(fu_a, fu_b, fu_sub);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pr[k] <= pr[k-1];
            end
        end
    end
    assign fu_valid_out = pv[LAT-1] | inject;
    assign fu_result    = pr[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int mptr  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant();
        int idx;
        if (!rst_n || !issue_en) return '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (req_valid[idx]) return NREQ'(1) << idx;
        end
        return '0;
    endfunction

    // One clock: check the grant, record accepted work, then check this cycle's response.
    task automatic step();
        logic [NREQ-1:0] eg;
        int              g;
        logic            in_rst;
        exp_t            e;
        #1;
        eg = model_grant();
        chk("req_ready", req_ready, eg);
        g = -1;
        for (int k = 0; k < NREQ; k++) if (eg[k]) g = k;
        in_rst = !rst_n;
        if (g >= 0) begin
            e.id   = g;
            e.data = bf_op(req_a[16*g +: 16], req_b[16*g +: 16], req_sub[g]);
        end
        @(posedge clk);
        cyc++;
        if (in_rst) begin
            q.delete();
            mptr = 0;
        end else if (g >= 0) begin
            e.due = cyc + LAT + 1;
            q.push_back(e);
            mptr = (g + 1) % NREQ;
        end
        #1;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("resp_valid", resp_valid, NREQ'(1) << q[0].id);
            chk("resp_id", resp_id, q[0].id);
            chk("resp_data", resp_data, q[0].data);
            void'(q.pop_front());
        end else begin
            chk("resp_quiet", resp_valid, '0);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_sub[i]        = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state();
        chk("rst_fu_valid", fu_valid, 0);
        chk("rst_fu_a", fu_a, 0);
        chk("rst_fu_b", fu_b, 0);
        chk("rst_fu_sub", fu_sub, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_idle", idle, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle && n < budget) begin step(); n++; end
        chk("idle_reached", idle, 1);
    endtask

    logic [NREQ-1:0] prev_g;

    initial begin
        // Reset: grants blocked even with every request high.
        issue_en  = 1'b1;
        req_valid = '1;
        #1;
        chk("ready_in_reset", req_ready, 0);
        do_reset();
        req_valid = '0;
        chk_reset_state();

        // Single request from requester 2: 1.0 + 2.0 = 3.0.
        set_op(2, 16'h3F80, 16'h4000, 1'b0);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        chk("t1_fu_valid", fu_valid, 1);
        chk("t1_fu_a", fu_a, 16'h3F80);
        chk("t1_fu_b", fu_b, 16'h4000);
        chk("t1_fu_sub", fu_sub, 0);
        for (int i = 0; i < 5; i++) step();
        chk("t1_resp_valid", resp_valid, 4'b0100);
        chk("t1_resp_id", resp_id, 2);
        chk("t1_resp_data", resp_data, 16'h4040);
        wait_idle(20);

        // All four at once from reset: grants 0,1,2,3 back to back.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, rnd_bf(), rnd_bf(), 1'($urandom_range(0, 1)));
        req_valid = '1;
        for (int k = 0; k < NREQ; k++) begin
            #1;
            chk("t2_grant_order", req_ready, NREQ'(1) << k);
            step();
            req_valid[k] = 1'b0;
        end
        wait_idle(20);

        // Fairness: requesters 0 and 3 alternate under constant load.
        req_valid = 4'b1001;
        prev_g    = '0;
        for (int k = 0; k < 8; k++) begin
            set_op(0, rnd_bf(), rnd_bf(), 1'($urandom_range(0, 1)));
            set_op(3, rnd_bf(), rnd_bf(), 1'($urandom_range(0, 1)));
            #1;
            chk("t3_alternate", req_ready, (k % 2 == 0) ? 4'b0001 : 4'b1000);
            chk("t3_no_repeat", (req_ready != prev_g), 1);
            prev_g = req_ready;
            step();
        end
        req_valid = '0;
        wait_idle(20);

        // issue_en gating: 1.0 - 1.0 from requester 1 waits for issue_en.
        issue_en  = 1'b0;
        set_op(1, 16'h3F80, 16'h3F80, 1'b1);
        req_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_gated", req_ready, 0);
            step();
        end
        issue_en = 1'b1;
        #1;
        chk("t4_released", req_ready, 4'b0010);
        step();
        req_valid = '0;
        for (int i = 0; i < 5; i++) step();
        chk("t4_resp_valid", resp_valid, 4'b0010);
        chk("t4_resp_data", resp_data, 16'h0000);
        wait_idle(20);

        // Randomized traffic with occasional issue_en drops.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NREQ; i++) set_op(i, rnd_bf(), rnd_bf(), 1'($urandom_range(0, 1)));
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            issue_en  = ($urandom_range(0, 7) != 0);
            step();
        end
        req_valid = '0;
        issue_en  = 1'b1;
        wait_idle(20);

        // Reset two cycles after two accepted requests: nothing comes back.
        set_op(0, 16'h4000, 16'h3F80, 1'b0);
        set_op(1, 16'h4040, 16'h3F80, 1'b1);
        req_valid = 4'b0011;
        step();
        step();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_state();
        for (int i = 0; i < 8; i++) step();
        chk("t5_no_orphan", err_orphan, 0);
        chk("t5_idle", idle, 1);

        // Orphan: a unit result with no tag sets the sticky error and yields no response.
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("t6_orphan_set", err_orphan, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t6_orphan_sticky", err_orphan, 1);
        end
        do_reset();
        chk("t6_orphan_cleared", err_orphan, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
